ram_row_loader: RTL and testbench

RAM_ROW_LOADER -- requirements
Module: ram_row_loader

---
 rtl/ram_loader_pkg.sv | 27 ++
 rtl/ram_row_loader_if.sv | 35 +++
 rtl/row_assembler.sv | 59 +++++
 rtl/ram_row_loader.sv | 121 ++++++++++++
 tb/tb_ram_row_loader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the RAM row loader.
//   state_e          : loader FSM states
//   NumFeaturesWidth : width of the num_features request field
//   MinFeatures/MinPoints : lower bounds of a legal load request
//   params_in_range  : legality check for a load request
package ram_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StSetup,
    StWrite,
    StHold,
    StDone
  } state_e;

  localparam int unsigned NumFeaturesWidth = 4;
  localparam int unsigned MinFeatures      = 1;
  localparam int unsigned MinPoints        = 1;

  function automatic logic params_in_range(input int unsigned nf, input int unsigned np,
                                           input int unsigned max_features,
                                           input int unsigned depth);
    return (nf >= MinFeatures) && (nf <= max_features) && (np >= MinPoints) && (np <= depth);
  endfunction

endpackage

// File: rtl/ram_row_loader_if.sv
// Bus bundle for ram_row_loader: load request, input word stream, RAM write port and status.
//   master : requester / stream source / RAM observer
//   slave  : the loader
interface ram_row_loader_if #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned MAX_FEATURES = 15,
  parameter int unsigned LENGTH       = 16,
  parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
);
  logic                                        start;
  logic [ADDR_WIDTH-1:0]                       num_points;
  logic [ram_loader_pkg::NumFeaturesWidth-1:0] num_features;
  logic [LENGTH-1:0]                           in_data;
  logic                                        in_valid;
  logic                                        in_ready;
  logic [ADDR_WIDTH-1:0]                       ram_addr;
  logic [DATA_WIDTH-1:0]                       ram_data;
  logic                                        ram_we;
  logic                                        ram_oe;
  logic                                        ram_drive;
  logic                                        busy;
  logic                                        done;
  logic                                        err;
  logic [ADDR_WIDTH-1:0]                       rows_written;

  modport master (
    output start, num_points, num_features, in_data, in_valid,
    input  in_ready, ram_addr, ram_data, ram_we, ram_oe, ram_drive, busy, done, err, rows_written
  );

  modport slave (
    input  start, num_points, num_features, in_data, in_valid,
    output in_ready, ram_addr, ram_data, ram_we, ram_oe, ram_drive, busy, done, err, rows_written
  );
endinterface

// File: rtl/row_assembler.sv
// Builds one RAM row from a stream of words.
//   CLK, RST       : clock, synchronous active-high reset
//   clear_i        : zero the row and restart slot counting
//   load_i         : store word_i into the current slot
//   word_i         : incoming word
//   num_features_i : feature words per row; the word after them is y
//   last_o         : the next loaded word is the y word
//   row_o          : assembled row
module row_assembler
  import ram_loader_pkg::*;
#(
  parameter int unsigned MAX_FEATURES = 15,
  parameter int unsigned LENGTH       = 16,
  parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        clear_i,
  input  logic                        load_i,
  input  logic [LENGTH-1:0]           word_i,
  input  logic [NumFeaturesWidth-1:0] num_features_i,
  output logic                        last_o,
  output logic [DATA_WIDTH-1:0]       row_o
);

  logic [DATA_WIDTH-1:0]       row_q, row_d;
  logic [NumFeaturesWidth-1:0] idx_q, idx_d;
  int unsigned                 slot;

  assign last_o = (idx_q == num_features_i);
  assign row_o  = row_q;

  always_comb begin
    row_d = row_q;
    idx_d = idx_q;
    // y always lands in the top slot regardless of the feature count
    slot  = last_o ? MAX_FEATURES : 32'(idx_q);
    if (clear_i) begin
      row_d = '0;
      idx_d = '0;
    end else if (load_i) begin
      for (int unsigned s = 0; s <= MAX_FEATURES; s++) begin
        if (s == slot) row_d[s*LENGTH +: LENGTH] = word_i;
      end
      if (!last_o) idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_q <= '0;
      idx_q <= '0;
    end else begin
      row_q <= row_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/ram_row_loader.sv
// Collects feature/y words into rows and writes them to consecutive RAM addresses
// with a SETUP / WRITE / HOLD sequence per row.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : request, word stream, RAM write port and status (slave side)
module ram_row_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned MAX_FEATURES = 15,
  parameter int unsigned LENGTH       = 16,
  parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
  parameter int unsigned DEPTH        = 100
) (
  input logic             CLK,
  input logic             RST,
  ram_row_loader_if.slave bus
);

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       num_points_q, num_points_d;
  logic [NumFeaturesWidth-1:0] num_features_q, num_features_d;
  logic [ADDR_WIDTH-1:0]       ram_addr_q, ram_addr_d;
  logic [ADDR_WIDTH-1:0]       rows_written_q, rows_written_d;
  logic                        err_q, err_d;
  logic                        asm_clear, asm_load, asm_last;
  logic [DATA_WIDTH-1:0]       row;

  row_assembler #(
    .MAX_FEATURES (MAX_FEATURES),
    .LENGTH       (LENGTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_row_assembler (
    .CLK            (CLK),
    .RST            (RST),
    .clear_i        (asm_clear),
    .load_i         (asm_load),
    .word_i         (bus.in_data),
    .num_features_i (num_features_q),
    .last_o         (asm_last),
    .row_o          (row)
  );

  always_comb begin
    state_d        = state_q;
    num_points_d   = num_points_q;
    num_features_d = num_features_q;
    ram_addr_d     = ram_addr_q;
    rows_written_d = rows_written_q;
    err_d          = 1'b0;
    asm_clear      = 1'b0;
    asm_load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (params_in_range(32'(bus.num_features), 32'(bus.num_points), MAX_FEATURES,
                              DEPTH)) begin
            state_d        = StCollect;
            num_points_d   = bus.num_points;
            num_features_d = bus.num_features;
            ram_addr_d     = '0;
            rows_written_d = '0;
            asm_clear      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StCollect: begin
        if (bus.in_valid) begin
          asm_load = 1'b1;
          if (asm_last) state_d = StSetup;
        end
      end
      StSetup: state_d = StWrite;
      StWrite: state_d = StHold;
      StHold: begin
        rows_written_d = rows_written_q + 1'b1;
        if (rows_written_d == num_points_q) begin
          state_d = StDone;
        end else begin
          // num_points <= DEPTH keeps the next address within the RAM
          ram_addr_d = ram_addr_q + 1'b1;
          asm_clear  = 1'b1;
          state_d    = StCollect;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StIdle;
      num_points_q   <= '0;
      num_features_q <= '0;
      ram_addr_q     <= '0;
      rows_written_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      num_points_q   <= num_points_d;
      num_features_q <= num_features_d;
      ram_addr_q     <= ram_addr_d;
      rows_written_q <= rows_written_d;
      err_q          <= err_d;
    end
  end

  assign bus.in_ready     = (state_q == StCollect);
  assign bus.ram_we       = (state_q == StWrite);
  assign bus.ram_oe       = 1'b0;
  assign bus.ram_drive    = (state_q != StIdle);
  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = (state_q == StDone);
  assign bus.err          = err_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_data     = row;
  assign bus.rows_written = rows_written_q;

endmodule

// File: tb/tb_ram_row_loader.sv
module tb_ram_row_loader;

  localparam int unsigned AW    = 12;
  localparam int unsigned MF    = 15;
  localparam int unsigned LEN   = 16;
  localparam int unsigned DW    = LEN * (MF + 1);
  localparam int unsigned DEPTH = 100;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ram_row_loader_if #(
    .ADDR_WIDTH   (AW),
    .MAX_FEATURES (MF),
    .LENGTH       (LEN),
    .DATA_WIDTH   (DW)
  ) bus ();

  ram_row_loader #(
    .ADDR_WIDTH   (AW),
    .MAX_FEATURES (MF),
    .LENGTH       (LEN),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- RAM-side monitor ----------------
  int              cyc       = 0;
  int              done_cnt  = 0;
  int              err_cnt   = 0;
  int              oe_cnt    = 0;
  int              stab_err  = 0;
  int              we_total  = 0;
  logic [AW-1:0]   wr_addr[$];
  logic [DW-1:0]   wr_data[$];
  int              wr_cyc[$];
  logic            prev_we   = 1'b0;
  logic [AW-1:0]   prev_addr = '0;
  logic [DW-1:0]   prev_data = '0;

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.err) err_cnt <= err_cnt + 1;
    if (bus.ram_oe) oe_cnt <= oe_cnt + 1;
    if (bus.ram_we) begin
      wr_addr.push_back(bus.ram_addr);
      wr_data.push_back(bus.ram_data);
      wr_cyc.push_back(cyc);
      we_total <= we_total + 1;
      // we must be a single cycle with address/data already set up the cycle before
      if (prev_we || bus.ram_addr != prev_addr || bus.ram_data != prev_data)
        stab_err <= stab_err + 1;
    end
    // address/data must still be held the cycle after the write
    if (prev_we && !RST && (bus.ram_addr != prev_addr || bus.ram_data != prev_data))
      stab_err <= stab_err + 1;
    prev_we   <= bus.ram_we;
    prev_addr <= bus.ram_addr;
    prev_data <= bus.ram_data;
  end

  // ---------------- reference model ----------------
  logic [LEN-1:0] words[$];

  function automatic logic [DW-1:0] model_row(input int nf, input int base);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < nf; k++) r[k*LEN +: LEN] = words[base + k];
    r[MF*LEN +: LEN] = words[base + nf];
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_start(input int nf, input int np);
    bus.num_features = nf[3:0];
    bus.num_points   = np[AW-1:0];
    bus.start        = 1'b1;
    @(negedge CLK);
    bus.start        = 1'b0;
  endtask

  task automatic push_word(input logic [LEN-1:0] w, input int gap, output bit ok);
    int t;
    ok = 1'b1;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(negedge CLK);
    end
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.in_ready) begin
      check("in_ready_wait", bus.in_ready, 1);
      ok = 1'b0;
    end else begin
      @(negedge CLK);  // word is taken on the edge just passed
    end
  endtask

  // gap_mode: 0 continuous, 1 valid toggling, 2 random gaps
  task automatic run_load(input string tag, input int nf, input int np, input int gap_mode,
                          input bit poke);
    int  base_w;
    int  base_done;
    int  gap;
    int  t;
    bit  ok;
    base_w    = wr_addr.size();
    base_done = done_cnt;
    do_start(nf, np);
    check({tag, "_busy"}, bus.busy, 1);
    ok = 1'b1;
    for (int i = 0; i < np * (nf + 1) && ok; i++) begin
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      if (poke && i == 1) begin
        bus.start        = 1'b1;
        bus.num_points   = 12'd1;
        bus.num_features = 4'd1;
      end
      push_word(words[i], gap, ok);
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.done && t < 300) begin
      @(negedge CLK);
      t++;
    end
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_rows_written"}, bus.rows_written, np);
    check({tag, "_final_addr"}, bus.ram_addr, np - 1);
    @(negedge CLK);
    check({tag, "_idle_after"}, bus.busy, 0);
    check({tag, "_done_pulses"}, done_cnt - base_done, 1);
    check({tag, "_write_count"}, wr_addr.size() - base_w, np);
    for (int i = 0; i < np && base_w + i < wr_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[base_w + i], i);
      check($sformatf("%s_row%0d", tag, i), wr_data[base_w + i], model_row(nf, i * (nf + 1)));
      if (gap_mode == 0 && i > 0)
        check($sformatf("%s_spacing%0d", tag, i),
              wr_cyc[base_w + i] - wr_cyc[base_w + i - 1], nf + 4);
    end
  endtask

  typedef struct {
    int nf;
    int np;
    bit exp_err;
  } start_vec_t;

  start_vec_t vecs[8];

  initial begin
    logic [DW-1:0] row_a;
    logic [DW-1:0] exp33;
    int            we0;
    int            nf;
    int            np;
    bit            ok;

    vecs[0] = '{2, 0, 1'b1};
    vecs[1] = '{2, 101, 1'b1};
    vecs[2] = '{0, 1, 1'b1};
    vecs[3] = '{0, 0, 1'b1};
    vecs[4] = '{15, 4095, 1'b1};
    vecs[5] = '{1, 1, 1'b0};
    vecs[6] = '{15, 100, 1'b0};
    vecs[7] = '{7, 100, 1'b0};

    bus.start        = 1'b0;
    bus.num_points   = '0;
    bus.num_features = '0;
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;

    // reset state
    repeat (3) @(negedge CLK);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_drive", bus.ram_drive, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done_err", {bus.done, bus.err}, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_data", bus.ram_data, 0);
    check("rst_rows_written", bus.rows_written, 0);
    RST = 1'b0;
    @(negedge CLK);

    // request legality table; legal requests are aborted by reset
    for (int i = 0; i < 8; i++) begin
      we0 = we_total;
      do_start(vecs[i].nf, vecs[i].np);
      check($sformatf("vec%0d_err", i), bus.err, vecs[i].exp_err);
      check($sformatf("vec%0d_busy", i), bus.busy, !vecs[i].exp_err);
      @(negedge CLK);
      check($sformatf("vec%0d_err_pulse", i), bus.err, 0);
      if (bus.busy) begin
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check($sformatf("vec%0d_abort", i), bus.busy, 0);
      end
      check($sformatf("vec%0d_no_we", i), we_total - we0, 0);
    end

    // single row, fixed words
    words = {16'h0011, 16'h0022, 16'h00AA};
    run_load("r33", 2, 1, 0, 1'b0);
    exp33 = {16'h00AA, 208'h0, 16'h0022, 16'h0011};
    if (wr_data.size() > 0) check("r33_literal_row", wr_data[wr_data.size() - 1], exp33);

    // full-width rows, three points, continuous stream
    words.delete();
    for (int i = 0; i < 48; i++) words.push_back(LEN'($urandom));
    run_load("r34", 15, 3, 0, 1'b0);

    // toggled valid gives the same row as continuous valid
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back(LEN'($urandom));
    run_load("r36c", 4, 1, 0, 1'b0);
    row_a = wr_data[wr_data.size() - 1];
    run_load("r36t", 4, 1, 1, 1'b0);
    check("r36_same_row", wr_data[wr_data.size() - 1], row_a);

    // reset after 2 of 5 words
    we0 = we_total;
    words = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    do_start(4, 1);
    push_word(words[0], 0, ok);
    push_word(words[1], 0, ok);
    bus.in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("r37_idle", bus.busy, 0);
    check("r37_in_ready", bus.in_ready, 0);
    check("r37_data_cleared", bus.ram_data, 0);
    check("r37_no_we", we_total - we0, 0);
    words = {16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E};
    run_load("r37_reload", 4, 1, 0, 1'b0);

    // start while busy is ignored
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(LEN'($urandom));
    run_load("r38", 3, 2, 0, 1'b1);

    // randomized loads against the model
    for (int r = 0; r < 6; r++) begin
      nf = int'($urandom_range(1, MF));
      np = int'($urandom_range(1, 4));
      words.delete();
      for (int i = 0; i < np * (nf + 1); i++) words.push_back(LEN'($urandom));
      run_load($sformatf("rnd%0d", r), nf, np, 2, 1'b0);
    end

    check("oe_never", oe_cnt, 0);
    check("we_stability", stab_err, 0);
    check("err_pulses", err_cnt, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
